stack_unit: RTL

Hardware operand stack for the stack-based multicycle processor. It sits directly downstream of the datapath's push/pop/tos control and feeds the top-of-stack value back into the datapath's A/B operand registers. The block holds `DEPTH` words of `WIDTH` bits with a registered read port and full/empty status. It flags overflow and underflow attempts without corrupting stored contents.

---
 rtl/stack_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// Operand stack: DEPTH x WIDTH register array with a registered read port and full/empty status.
// Optional macro STACK_ERR_STICKY_EN makes ovf/udf sticky and freezes the stack while either is set.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int SPW = $clog2(DEPTH + 1),
  localparam int IW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SPW-1:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;
  logic             is_empty, is_full;
  logic             frozen;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SPW'(DEPTH));
  assign top_idx  = IW'(sp_q - SPW'(1));

`ifdef STACK_ERR_STICKY_EN
  assign frozen = ovf_q | udf_q;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    wr_en  = 1'b0;
    wr_idx = IW'(sp_q);
`ifdef STACK_ERR_STICKY_EN
    ovf_d  = ovf_q;
    udf_d  = udf_q;
`else
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
`endif
    if (!frozen) begin
      if (push && pop) begin
        if (is_empty) begin
          // Pop half is rejected, but the push still lands in slot 0.
          wr_en  = 1'b1;
          wr_idx = '0;
          sp_d   = SPW'(1);
          udf_d  = 1'b1;
        end else begin
          dout_d = mem_q[top_idx];
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end
      end else if (push) begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + SPW'(1);
        end
      end else if (pop || tos) begin
        if (is_empty) begin
          udf_d = 1'b1;
        end else begin
          dout_d = mem_q[top_idx];
          if (pop) sp_d = sp_q - SPW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage is not reset; a command sampled while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= din;
  end

  assign dout  = dout_q;
  assign count = sp_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule
